// File: rtl/fe_instr_q_pkg.sv
// Shared types and constants for the front-end instruction queue.
// t_instr_pkt is the fetch packet handed from fetch to decode; FE_INSTR_Q_DEPTH
// is the depth used by the core-level instantiation.
package fe_instr_q_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] simid;
  } t_instr_pkt;

  localparam int FE_INSTR_Q_DEPTH = 4;

endpackage

// File: rtl/fe_instr_q.sv
// Instruction queue between fetch and decode.
// Buffers up to DEPTH fetch packets and presents them to decode in push order.
// A branch mispredict flushes everything so no wrong-path packet reaches decode.
// Optional macro FE_INSTR_Q_BYPASS_EN: when the queue is empty, a fetch packet
// is forwarded combinationally to decode (zero-cycle latency) and is only
// written into storage if decode stalls that cycle.
//
// Handshake: fetch offers instr_fe1 while valid_fe1=1 and holds it stable until a
// cycle where stall_fe=0 (transfer happens at that clock edge). Decode takes
// instr_de0 on any cycle where valid_de0=1 and stall_de=0. A flush cycle
// (br_mispred_rb1=1) transfers nothing in either direction.
module fe_instr_q
  import fe_instr_q_pkg::*;
#(
  parameter int DEPTH = FE_INSTR_Q_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       br_mispred_rb1,
  input  logic       valid_fe1,
  input  t_instr_pkt instr_fe1,
  output logic       stall_fe,
  output logic       valid_de0,
  output t_instr_pkt instr_de0,
  input  logic       stall_de
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  t_instr_pkt    entries_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic q_empty;
  logic push;
  logic pop;
  logic bypass_take;
  logic wr_en;
  logic rd_en;

  assign q_empty  = (count_q == '0);
  // Full flag comes straight from the count flop: no path from stall_de.
  assign stall_fe = (count_q == FULL_CNT);
  assign push     = valid_fe1 & ~stall_fe & ~br_mispred_rb1;
  assign pop      = valid_de0 & ~stall_de & ~br_mispred_rb1;

`ifdef FE_INSTR_Q_BYPASS_EN
  logic bypass;
  assign bypass      = q_empty & valid_fe1 & ~br_mispred_rb1;
  assign valid_de0   = ~q_empty | bypass;
  assign instr_de0   = !q_empty ? entries_q[rd_ptr_q] : (bypass ? instr_fe1 : '0);
  // Forwarded and consumed in the same cycle: never stored.
  assign bypass_take = bypass & ~stall_de;
`else
  assign valid_de0   = ~q_empty;
  assign instr_de0   = q_empty ? '0 : entries_q[rd_ptr_q];
  assign bypass_take = 1'b0;
`endif

  // A bypassed packet is popped straight from the fetch bus, not from storage.
  assign wr_en = push & ~bypass_take;
  assign rd_en = pop & ~q_empty;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  // Pointer/count registers; reset wins over flush, flush empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (br_mispred_rb1) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries_q[wr_ptr_q] <= instr_fe1;
    end
  end

`ifdef ASSERT
  logic [31:0] last_simid_q;
  logic        have_last_q;

  // SIMIDs seen by decode must strictly increase between flushes/resets.
  always_ff @(posedge clk) begin
    if (reset || br_mispred_rb1) begin
      have_last_q <= 1'b0;
    end else if (pop) begin
      if (have_last_q) begin
        assert (instr_de0.simid > last_simid_q)
          else $error("fe_instr_q: SIMID order violated (%0d after %0d)",
                      instr_de0.simid, last_simid_q);
      end
      last_simid_q <= instr_de0.simid;
      have_last_q  <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/fe_instr_q.md
Name: fe_instr_q

Overview:
- Instruction queue between fetch (producer of valid_fe1/instr_fe1) and decode (consumer).
- Decouples decode back-pressure from fetch: absorbs up to DEPTH instruction packets and presents them in order to decode.
- Flushes on branch mispredict so no wrong-path instruction reaches decode after the redirect cycle.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- br_mispred_rb1  input  1  mispredict flush from retire; clears queue
- valid_fe1  input  1  fetch packet valid
- instr_fe1  input  t_instr_pkt  fetch packet (pc, instr, SIMID); held stable by fetch while stall_fe is high
- stall_fe  output  1  back-pressure to fetch; drives fetch's stall input
- valid_de0  output  1  head packet valid to decode
- instr_de0  output  t_instr_pkt  head packet to decode
- stall_de  input  1  decode cannot accept this cycle

Behaviour:
- Reset: count=0, wr_ptr=0, rd_ptr=0, valid_de0=0, stall_fe=0. Entry contents are don't-care, but instr_de0 is driven as 0 while the queue is empty.
- Widths: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- push = valid_fe1 & ~stall_fe & ~br_mispred_rb1. On push: entries[wr_ptr] <= instr_fe1; wr_ptr++.
- pop = valid_de0 & ~stall_de & ~br_mispred_rb1. On pop: rd_ptr++.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged, including at count=DEPTH-1.
- stall_fe = (count == DEPTH). Depends on flops only; there is no combinational path from stall_de to stall_fe.
- Full with simultaneous pop: stall_fe remains 1 that cycle and the fetch packet is not taken. It is accepted in the next cycle.
- valid_de0 = (count != 0). instr_de0 = entries[rd_ptr].
- Latency: a packet pushed in cycle N is visible to decode in cycle N+1 (without the bypass feature).
- Decode stall: instr_de0 and valid_de0 hold stable while stall_de=1 and no flush occurs.
- Flush (br_mispred_rb1=1):
  - Next cycle: count=0, wr_ptr=rd_ptr=0, valid_de0=0.
  - Any same-cycle push is dropped; no pop is counted.
  - First post-flush packet (the branch target) is pushed no earlier than the cycle after flush.
- Reset has priority over flush. Reset mid-operation discards all entries with no partial output.
- Ordering: packets leave in exactly push order. No duplication, no loss except by flush.

Optional Feature:
- Macro: FE_INSTR_Q_BYPASS_EN.
- Defined:
  - When count==0 and valid_fe1 & ~br_mispred_rb1: valid_de0=1 and instr_de0=instr_fe1 combinationally, giving zero-cycle latency.
  - If ~stall_de that cycle, the packet is consumed directly and is not written; count stays 0.
  - If stall_de, the packet is written as a normal push.
  - stall_fe is unchanged (still count-based).
- Undefined: the one-cycle latency above applies; there is no combinational fetch-to-decode path.

Decomposition:
- instr package: t_instr_pkt (existing).
- common package: localparam FE_INSTR_Q_DEPTH = 4, used by the core top instantiation.
- No new typedef is required. Pointer and count widths are derived locally from DEPTH.
- No sub-module is natural: storage array, pointers and count are one flat module. Under ASSERT, include an inline SIMID-order check (monotonic SIMID between consecutive pops, reset by flush).

Test Plan:
- Single packet: valid_fe1=1 for 1 cycle with pc=0x100, stall_de=0.
  - Without bypass: valid_de0=1 next cycle only, instr_de0.pc=0x100.
  - With FE_INSTR_Q_BYPASS_EN: valid_de0=1 the same cycle.
- Fill: stall_de=1, push pcs 0x0,0x4,0x8,0xC (DEPTH=4) -> stall_fe=1 after the 4th push; a 5th pc 0x10 is held by fetch. Release stall_de -> pops in order 0x0..0xC, then 0x10. stall_fe drops the cycle after the first pop.
- Streaming: continuous valid_fe1 with stall_de=0 for 20 cycles -> one packet out per cycle, count never exceeds 1, stall_fe never asserts.
- Wrap-around: alternate 3 pushes / 2 pops for 16 cycles -> pointers wrap past DEPTH-1. Output pc sequence equals input sequence; no duplicates or drops.
- Flush: queue holds 3 entries, br_mispred_rb1=1 together with push pc 0x40 -> next cycle valid_de0=0, count=0, 0x40 never appears. Push target 0x200 the following cycle -> it is the next packet decode sees.
- Reset mid-stream: full queue, assert reset 1 cycle -> valid_de0=0, stall_fe=0 next cycle. The first post-reset push appears alone at the output.
